// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core's
// load/store path and a debug/loader master. The debug master wins while
// the core is waiting, but only for a bounded burst, so the core cannot starve.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core load/store path
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic [2:0]            core_load_sel,
  input  logic [1:0]            core_store_sel,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  // debug / loader master
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  // data memory port
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_load_sel,
  output logic [1:0]            mem_store_sel,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  localparam logic [2:0] LOAD_WORD  = 3'b010;
  localparam logic [1:0] STORE_WORD = 2'b10;

  logic [CNT_W-1:0]      burst_cnt_reg;
  logic [CNT_W-1:0]      burst_cnt_next;
  logic                  dbg_rvalid_reg;
  logic [DATA_WIDTH-1:0] dbg_rdata_reg;

  logic dbg_owner;
  logic core_owner;

  // Ownership: debug wins unless the core has already waited a full burst.
  always_comb begin
    dbg_owner  = dbg_req & (~core_req | (burst_cnt_reg < MAX_CNT));
    core_owner = core_req & ~dbg_owner;
  end

  // Burst counter only advances while the core is actually waiting; any core
  // grant or core idle cycle restarts the budget. At MAX_CNT the core wins,
  // so the counter cannot go past it.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (!core_req || core_owner) begin
      burst_cnt_next = '0;
    end else if (dbg_owner && (burst_cnt_reg < MAX_CNT)) begin
      burst_cnt_next = burst_cnt_reg + CNT_W'(1);
    end
  end

  // Memory port mux. Idle cycles park on word encodings with no write, and a
  // stalled core store never reaches the memory because only the owner drives it.
  always_comb begin
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wr_en     = 1'b0;
    mem_load_sel  = LOAD_WORD;
    mem_store_sel = STORE_WORD;
    if (core_owner) begin
      mem_addr      = core_addr;
      mem_wdata     = core_wdata;
      mem_wr_en     = core_we;
      mem_load_sel  = core_load_sel;
      mem_store_sel = core_store_sel;
    end else if (dbg_owner) begin
      mem_addr      = dbg_addr;
      mem_wdata     = dbg_wdata;
      mem_wr_en     = dbg_we;
    end
  end

  // Burst counter and debug read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_reg  <= '0;
      dbg_rvalid_reg <= 1'b0;
      dbg_rdata_reg  <= '0;
    end else begin
      burst_cnt_reg  <= burst_cnt_next;
      dbg_rvalid_reg <= dbg_owner & ~dbg_we;
      if (dbg_owner && !dbg_we) begin
        dbg_rdata_reg <= mem_rdata;
      end
    end
  end

  assign core_rdata = mem_rdata;
  assign core_stall = core_req & ~core_owner;
  assign dbg_gnt    = dbg_owner;
  assign dbg_rvalid = dbg_rvalid_reg;
  assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small word-wide
// DMEM model (combinational read, synchronous write, held off during reset).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [2:0]  core_load_sel = 3'b010;
  logic [1:0]  core_store_sel = 2'b10;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [2:0]  mem_load_sel;
  logic [1:0]  mem_store_sel;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int wr200_cnt = 0;

  logic [31:0] mem [0:1023];

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_load_sel(core_load_sel),
    .core_store_sel(core_store_sel), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_load_sel(mem_load_sel), .mem_store_sel(mem_store_sel),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (rst_n && mem_wr_en) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      if (mem_addr == 32'h200) wr200_cnt <= wr200_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0;
    dbg_req  = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // ---------------- reset state ----------------
    #2;
    check("rst_stall", core_stall, 0);
    check("rst_gnt", dbg_gnt, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rvalid", dbg_rvalid, 0);
    check("rst_rdata", dbg_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_load_sel", mem_load_sel, 3'b010);
    check("rst_store_sel", mem_store_sel, 2'b10);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- core-only store then load ----------------
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100;
    core_wdata = 32'hDEADBEEF; core_store_sel = 2'b10; core_load_sel = 3'b100;
    #1;
    check("cst_stall", core_stall, 0);
    check("cst_wr_en", mem_wr_en, 1);
    check("cst_addr", mem_addr, 32'h100);
    check("cst_wdata", mem_wdata, 32'hDEADBEEF);
    check("cst_load_sel_pass", mem_load_sel, 3'b100);
    tick();
    core_we = 1'b0; core_load_sel = 3'b010; core_store_sel = 2'b01;
    #1;
    check("cld_stall", core_stall, 0);
    check("cld_wr_en", mem_wr_en, 0);
    check("cld_store_sel_pass", mem_store_sel, 2'b01);
    check("cld_rdata", core_rdata, 32'hDEADBEEF);
    core_store_sel = 2'b10;
    idle();

    // ---------------- debug-only read ----------------
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    #1;
    check("drd_gnt", dbg_gnt, 1);
    check("drd_addr", mem_addr, 32'h100);
    check("drd_wr_en", mem_wr_en, 0);
    check("drd_rvalid_early", dbg_rvalid, 0);
    tick();
    dbg_req = 1'b0;
    #1;
    check("drd_rvalid", dbg_rvalid, 1);
    check("drd_rdata", dbg_rdata, 32'hDEADBEEF);
    tick();
    check("drd_rvalid_pulse", dbg_rvalid, 0);
    check("drd_rdata_hold", dbg_rdata, 32'hDEADBEEF);

    // ---------------- sustained contention: 4 debug, 1 core ----------------
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("cont_gnt_%0d", i), dbg_gnt, (i % 5) != 4);
      check($sformatf("cont_stall_%0d", i), core_stall, (i % 5) != 4);
      if (i > 0) check($sformatf("cont_rvalid_%0d", i), dbg_rvalid, ((i - 1) % 5) != 4);
      tick();
    end
    idle();
    idle();

    // ---------------- stalled store vs. two debug writes ----------------
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h204; dbg_wdata = 32'h22;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("sst_gnt_%0d", i), dbg_gnt, 1);
      check($sformatf("sst_stall_%0d", i), core_stall, 1);
      check($sformatf("sst_addr_%0d", i), mem_addr, 32'h204);
      tick();
      check($sformatf("sst_norvalid_%0d", i), dbg_rvalid, 0);
    end
    dbg_req = 1'b0;
    #1;
    check("sst_core_stall", core_stall, 0);
    check("sst_core_wr", mem_wr_en, 1);
    check("sst_wr200_before", wr200_cnt, 0);
    tick();
    core_we = 1'b0; core_addr = 32'h204;
    #1;
    check("sst_wr200_once", wr200_cnt, 1);
    check("sst_rd204", core_rdata, 32'h22);
    tick();
    core_addr = 32'h200;
    #1;
    check("sst_rd200", core_rdata, 32'h11);
    idle();
    check("sst_wr200_final", wr200_cnt, 1);

    // ---------------- reset in the middle of a contended read ----------------
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h100;
    tick();
    tick();
    #1;
    check("rmr_gnt", dbg_gnt, 1);
    rst_n = 1'b0;
    #1;
    check("rmr_rvalid_now", dbg_rvalid, 0);
    tick();
    check("rmr_rvalid_edge", dbg_rvalid, 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rmr_rvalid_rel", dbg_rvalid, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rmr_gnt_%0d", i), dbg_gnt, i < 4);
      check($sformatf("rmr_stall_%0d", i), core_stall, i < 4);
      tick();
    end
    idle();

    // ---------------- core drops its request mid-burst ----------------
    core_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
    tick();
    tick();
    core_req = 1'b0;
    #1;
    check("crl_gnt", dbg_gnt, 1);
    check("crl_stall", core_stall, 0);
    tick();
    core_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("crl_gnt_%0d", i), dbg_gnt, i < 4);
      check($sformatf("crl_stall_%0d", i), core_stall, i < 4);
      tick();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
